uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter sharing the single UART transmit FIFO write port (we/data/full) among several byte producers (core MMIO path, debug monitor, trace unit). A requester that wins arbitration keeps the port until it transfers a byte tagged `last`, so multi-byte messages are never interleaved on the serial line. The block sits directly in front of the UART transmitter and is the only writer of its queue.

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the UART transmit queue.
// master: producer/queue side (drives requests and queue-full), slave: the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_full;
    logic                 tx_we;
    logic [7:0]           tx_data;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tx_we, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tx_we, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the UART transmit queue write port.
// An owner keeps the port until it transfers a byte tagged last, so packets never interleave.
// Optional feature: define UART_ARB_TIMEOUT_EN to force-release a lock whose owner stays idle
// for TIMEOUT consecutive cycles (timeout_o pulses once on release).
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    uart_tx_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..65535");
    end

    typedef enum logic {StIdle, StLocked} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   g_q, g_d;
    logic [IdxW-1:0]   g_inc;
    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic              owner_valid, owner_last, xfer;
    logic [7:0]        owner_data;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]       cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
`endif

    // Owner's view of the request bus; the byte lane is selected by {g, 3'b000}.
    assign owner_valid = bus.req_valid[g_q];
    assign owner_last  = bus.req_last[g_q];
    assign owner_data  = bus.req_data[{g_q, 3'b000} +: 8];
    assign g_inc       = (g_q == IdxW'(NUM_REQ - 1)) ? '0 : g_q + IdxW'(1);
    assign xfer        = (state_q == StLocked) && owner_valid && !bus.tx_full;

    // Round-robin pick: first valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!pick_found && bus.req_valid[IdxW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(cand);
            end
        end
    end

    // Next-state logic and the combinational data path to the queue.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        g_d           = g_q;
        bus.req_ready = '0;
        bus.tx_we     = 1'b0;
        bus.tx_data   = 8'h00;
        grant_o       = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    g_d     = pick_idx;
                    state_d = StLocked;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StLocked: begin
                bus.req_ready[g_q] = !bus.tx_full;
                bus.tx_we          = xfer;
                bus.tx_data        = owner_data;
                grant_o[g_q]       = 1'b1;
                if (xfer) begin
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (owner_last) begin
                        state_d = StIdle;
                        ptr_d   = g_inc;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Only cycles with the owner idle count; a full-stalled owner does not.
                else if (!owner_valid) begin
                    if (cnt_q == 16'(TIMEOUT - 1)) begin
                        state_d   = StIdle;
                        ptr_d     = g_inc;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o = (state_q == StLocked);

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // State registers; reset drops any lock immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            g_q       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= g_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized run
// against a packet-level reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [N-1:0] grant_o;
    logic         busy_o;
    logic         timeout_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    bit m_locked;
    int m_g;
    int m_ptr;
    int m_idle;
    bit m_to;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (TO)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .bus       (bus),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.tx_full   = 1'b0;
    endtask

    task automatic set_byte(input int k, input logic [7:0] b);
        bus.req_data[8*k +: 8] = b;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        next_cycle();
        rst_ni   = 1'b1;
        m_locked = 0;
        m_g      = 0;
        m_ptr    = 0;
        m_idle   = 0;
        m_to     = 0;
    endtask

    function automatic int model_pick(input int ptr, input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    // Advance the model across one clock edge given the inputs sampled before it.
    task automatic model_edge(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        bit to_next;
        int p;
        to_next = 0;
        if (!m_locked) begin
            p = model_pick(m_ptr, v);
            if (p >= 0) begin
                m_locked = 1;
                m_g      = p;
                m_idle   = 0;
            end
        end else if (v[m_g] && !f) begin
            m_idle = 0;
            if (l[m_g]) begin
                m_locked = 0;
                m_ptr    = (m_g + 1) % N;
            end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!v[m_g]) begin
            m_idle++;
            if (m_idle == TO) begin
                m_locked = 0;
                m_ptr    = (m_g + 1) % N;
                m_idle   = 0;
                to_next  = 1;
            end
        end
`endif
        m_to = to_next;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        rst_ni        = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, grant_o, bus.tx_we, bus.tx_data, bus.req_ready, timeout_o} !==
            {1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b grant=%b we=%b data=%h ready=%b to=%b, want all 0",
                     busy_o, grant_o, bus.tx_we, bus.tx_data, bus.req_ready, timeout_o);
        end
        next_cycle();
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        bus.req_valid = 4'b0110;
        bus.req_last  = 4'b0110;
        set_byte(1, 8'h41);
        set_byte(2, 8'h52);
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, grant_o, bus.tx_we} !== {1'b0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_arb_cycle: got busy=%b grant=%b we=%b want 0 0000 0",
                     busy_o, grant_o, bus.tx_we);
        end
        next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, grant_o, bus.tx_we, bus.tx_data, bus.req_ready} !==
            {1'b1, 4'b0010, 1'b1, 8'h41, 4'b0010}) begin
            n_fail++;
            $display("FAIL basic_grant1: got busy=%b grant=%b we=%b data=%h ready=%b want 1 0010 1 41 0010",
                     busy_o, grant_o, bus.tx_we, bus.tx_data, bus.req_ready);
        end
        next_cycle();
        bus.req_valid = 4'b0100;
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, grant_o, bus.tx_we} !== {1'b0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_bubble: got busy=%b grant=%b we=%b want 0 0000 0",
                     busy_o, grant_o, bus.tx_we);
        end
        next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, grant_o, bus.tx_we, bus.tx_data, bus.req_ready} !==
            {1'b1, 4'b0100, 1'b1, 8'h52, 4'b0100}) begin
            n_fail++;
            $display("FAIL basic_grant2: got busy=%b grant=%b we=%b data=%h ready=%b want 1 0100 1 52 0100",
                     busy_o, grant_o, bus.tx_we, bus.tx_data, bus.req_ready);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_packet();
        logic [7:0] b;
        do_reset();
        bus.req_valid = 4'b1001;
        bus.req_last  = 4'b1000;
        set_byte(3, 8'h33);
        set_byte(0, 8'h10);
        @(negedge clk_i);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            b = 8'(8'h10 + i);
            set_byte(0, b);
            bus.req_last[0] = (i == 2);
            @(negedge clk_i);
            n_cmp++;
            if ({busy_o, grant_o, bus.tx_we, bus.tx_data, bus.req_ready} !==
                {1'b1, 4'b0001, 1'b1, b, 4'b0001}) begin
                n_fail++;
                $display("FAIL packet_byte%0d: got grant=%b we=%b data=%h ready=%b want 0001 1 %h 0001",
                         i, grant_o, bus.tx_we, bus.tx_data, bus.req_ready, b);
            end
            next_cycle();
        end
        bus.req_valid = 4'b1000;
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, grant_o, bus.tx_we} !== {1'b0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL packet_bubble: got busy=%b grant=%b we=%b want 0 0000 0",
                     busy_o, grant_o, bus.tx_we);
        end
        next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if ({grant_o, bus.tx_we, bus.tx_data} !== {4'b1000, 1'b1, 8'h33}) begin
            n_fail++;
            $display("FAIL packet_req3: got grant=%b we=%b data=%h want 1000 1 33",
                     grant_o, bus.tx_we, bus.tx_data);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_full_stall();
        int writes;
        do_reset();
        bus.req_valid = 4'b0100;
        set_byte(2, 8'h20);
        @(negedge clk_i);
        next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if ({bus.tx_we, bus.tx_data} !== {1'b1, 8'h20}) begin
            n_fail++;
            $display("FAIL full_first_byte: got we=%b data=%h want 1 20", bus.tx_we, bus.tx_data);
        end
        next_cycle();
        set_byte(2, 8'hA5);
        bus.req_last = 4'b0100;
        bus.tx_full  = 1'b1;
        writes       = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if ({busy_o, grant_o, bus.tx_we, bus.req_ready} !== {1'b1, 4'b0100, 1'b0, 4'b0000}) begin
                n_fail++;
                $display("FAIL full_stall_c%0d: got busy=%b grant=%b we=%b ready=%b want 1 0100 0 0000",
                         c, busy_o, grant_o, bus.tx_we, bus.req_ready);
            end
            next_cycle();
        end
        bus.tx_full = 1'b0;
        @(negedge clk_i);
        if (bus.tx_we) writes++;
        n_cmp++;
        if ({bus.tx_we, bus.tx_data, bus.req_ready} !== {1'b1, 8'hA5, 4'b0100}) begin
            n_fail++;
            $display("FAIL full_release: got we=%b data=%h ready=%b want 1 a5 0100",
                     bus.tx_we, bus.tx_data, bus.req_ready);
        end
        next_cycle();
        bus.req_valid = '0;
        repeat (2) begin
            @(negedge clk_i);
            if (bus.tx_we) writes++;
            next_cycle();
        end
        n_cmp++;
        if (writes !== 1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_single_write: got writes=%0d busy=%b want 1 0", writes, busy_o);
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int         e;
        logic [N-1:0] eg;
        logic [7:0] ed;
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        for (int k = 0; k < N; k++) set_byte(k, 8'(8'hC0 + k));
        for (int p = 0; p < 5; p++) begin
            e  = p % N;
            eg = N'(1 << e);
            ed = 8'(8'hC0 + e);
            @(negedge clk_i);
            n_cmp++;
            if (grant_o !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_bubble%0d: got grant=%b want 0000", p, grant_o);
            end
            next_cycle();
            @(negedge clk_i);
            n_cmp++;
            if ({grant_o, bus.tx_we, bus.tx_data} !== {eg, 1'b1, ed}) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got grant=%b we=%b data=%h want %b 1 %h",
                         p, grant_o, bus.tx_we, bus.tx_data, eg, ed);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0010;
        set_byte(1, 8'h21);
        next_cycle();
        next_cycle();
        bus.req_valid = 4'b1000;
        bus.req_last  = 4'b0000;
        set_byte(3, 8'h31);
        next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, grant_o} !== {1'b1, 4'b1000}) begin
            n_fail++;
            $display("FAIL areset_locked: got busy=%b grant=%b want 1 1000", busy_o, grant_o);
        end
        next_cycle();
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, grant_o, bus.tx_we, bus.req_ready} !== {1'b0, 4'b0000, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL areset_drop: got busy=%b grant=%b we=%b ready=%b want all 0",
                     busy_o, grant_o, bus.tx_we, bus.req_ready);
        end
        @(negedge clk_i);
        rst_ni        = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if (grant_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL areset_restart: got grant=%b want 0001", grant_o);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req_valid = 4'b0010;
        set_byte(1, 8'h61);
        next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if ({bus.tx_we, bus.tx_data} !== {1'b1, 8'h61}) begin
            n_fail++;
            $display("FAIL to_first_byte: got we=%b data=%h want 1 61", bus.tx_we, bus.tx_data);
        end
        next_cycle();
        bus.req_valid = '0;
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if ({busy_o, timeout_o} !== 2'b10) begin
                n_fail++;
                $display("FAIL to_wait%0d: got busy=%b to=%b want 1 0", c, busy_o, timeout_o);
            end
            next_cycle();
        end
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, timeout_o, grant_o} !== {1'b0, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL to_pulse: got busy=%b to=%b grant=%b want 0 1 0000",
                     busy_o, timeout_o, grant_o);
        end
        next_cycle();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, timeout_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL to_pulse_end: got busy=%b to=%b want 0 0", busy_o, timeout_o);
        end
        next_cycle();
        @(negedge clk_i);
        n_cmp++;
        if (grant_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL to_ptr: got grant=%b want 0100", grant_o);
        end
        next_cycle();
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if ({busy_o, timeout_o, grant_o} !== {1'b1, 1'b0, 4'b0010}) begin
                n_fail++;
                $display("FAIL to_hold%0d: got busy=%b to=%b grant=%b want 1 0 0010",
                         c, busy_o, timeout_o, grant_o);
            end
            next_cycle();
        end
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0010;
        @(negedge clk_i);
        n_cmp++;
        if ({bus.tx_we, grant_o} !== {1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL to_finish: got we=%b grant=%b want 1 0010", bus.tx_we, grant_o);
        end
        next_cycle();
`endif
        idle_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0] r_valid, r_last;
        logic [7:0]   r_data [N];
        logic         r_full;
        logic [N-1:0] e_grant, e_ready;
        logic         e_we, e_busy, e_to;
        logic [7:0]   e_data;
        do_reset();
        r_valid = '0;
        r_last  = '0;
        for (int k = 0; k < N; k++) r_data[k] = 8'h00;
        for (int cyc = 0; cyc < 600; cyc++) begin
            r_full        = ($urandom_range(0, 3) == 0);
            bus.req_valid = r_valid;
            bus.req_last  = r_last;
            for (int k = 0; k < N; k++) set_byte(k, r_data[k]);
            bus.tx_full   = r_full;

            e_busy  = m_locked;
            e_grant = m_locked ? N'(1 << m_g) : '0;
            e_ready = (m_locked && !r_full) ? N'(1 << m_g) : '0;
            e_we    = m_locked && r_valid[m_g] && !r_full;
            e_data  = m_locked ? r_data[m_g] : 8'h00;
            e_to    = m_to;

            @(negedge clk_i);
            n_cmp++;
            if ({busy_o, grant_o, bus.req_ready, bus.tx_we, bus.tx_data, timeout_o} !==
                {e_busy, e_grant, e_ready, e_we, e_data, e_to}) begin
                n_fail++;
                $display("FAIL rand_c%0d: got busy=%b grant=%b ready=%b we=%b data=%h to=%b want %b %b %b %b %h %b",
                         cyc, busy_o, grant_o, bus.req_ready, bus.tx_we, bus.tx_data, timeout_o,
                         e_busy, e_grant, e_ready, e_we, e_data, e_to);
            end

            model_edge(r_valid, r_last, r_full);

            // Producers obey valid/ready: hold until accepted, then maybe offer a new byte.
            for (int k = 0; k < N; k++) begin
                if (r_valid[k] && e_ready[k]) begin
                    r_valid[k] = ($urandom_range(0, 7) != 0);
                    r_data[k]  = 8'($urandom);
                    r_last[k]  = ($urandom_range(0, 2) == 0);
                end else if (!r_valid[k]) begin
                    r_valid[k] = ($urandom_range(0, 3) == 0);
                    r_data[k]  = 8'($urandom);
                    r_last[k]  = ($urandom_range(0, 2) == 0);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_basic();
        test_packet();
        test_full_stall();
        test_round_robin();
        test_async_reset();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
